mem_ex: RTL and testbench
=========================

# mem_ex

Execute stage plus EX/MEM pipeline register of the five-stage RV32I pipeline. Takes ID/EX-registered operands and control, applies operand forwarding, computes the ALU result and the branch/jump target, and registers everything the MEM stage needs on the rising clock edge.

## Interface
Parameters: none.
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-low reset
- memtoreg_IDEX_out, regwrite_IDEX_out, memread_IDEX_out, memwrite_IDEX_out  in  1 each  control bits passed through to MEM
- branch_IDEX_out  in  1  instruction is a conditional branch
- alusrc_IDEX_out  in  1  1: ALU operand B is the immediate; 0: rs2
- i_type_IDEX_out  in  1  OP-IMM instruction
- lui_flag_IDEX_out  in  1  LUI instruction
- jalr_fla_IDEX_out  in  1  JALR instruction
- regwrite_MEMEX_out  in  1  MEM/WB regwrite, for forwarding
- aluop_IDEX_out  in  2  ALU class
- AJ_control_IDEX_out  in  2  writeback-select code, passed through
- IF_IDEX_PC_ID_out  in  32  instruction PC
- readdata1_IDEX_out, readdata2_IDEX_out  in  32  rs1 / rs2 register values
- gen_out_IDEX_out  in  32  sign-extended immediate
- adder1_IDEX  in  32  PC+4, passed through
- writingData_MEMWB  in  32  WB-stage write data, for forwarding
- ALU_result_EX_out  in  32  EX/MEM-stage result fed back, for forwarding
- function3_out_IDEX_out  in  4  {funct7[5], funct3}
- WData_IDEX_out, RS1_IDEX, RS2_IDEX  in  5  rd, rs1, rs2
- WData_MEM_out  in  5  MEM/WB rd
- memtoreg_MEMEX_out, memread_MEMEX_out, memwrite_MEMEX_out, regwrite_MEMEX_out2  out  1  registered control
- AJ_control_MEMEX_out  out  2  registered
- ALU_result_MEMEX_out  out  32  registered ALU result
- readdata2_MEMEX_out  out  32  registered store data (forwarded rs2)
- adder1_IDEX_MEM  out  32  registered PC+4
- adder2_MEM  out  32  registered branch/jump target
- WData_MEMEX_out  out  5  registered rd
- function3_out_MEMEX_out  out  4  registered function code

## Operation
- Forward A and B are evaluated independently for rs1 and rs2.
  - Priority 1, EX/MEM: the source register is not x0, regwrite_MEMEX_out2=1 and WData_MEMEX_out matches it. Use ALU_result_EX_out.
  - Priority 2, MEM/WB: the source register is not x0, regwrite_MEMEX_out=1 and WData_MEM_out matches it. Use writingData_MEMWB.
  - Otherwise use readdata1/readdata2.
- Operand A is forwarded rs1. Operand B is gen_out when alusrc=1, else forwarded rs2.
- ALU result is selected as follows:
  - lui_flag=1: result is gen_out. This overrides aluop.
  - aluop 00: A+B.
  - aluop 01 (compare): result is {31'b0, taken}. funct3 000 beq, 001 bne, 100 blt, 101 bge, 110 bltu, 111 bgeu; other codes give 0.
  - aluop 10: decoded from {b3,f3}.
    - 0000 add; 1000 sub, but add when i_type=1.
    - 0001 sll, 0010 slt, 0011 sltu, 0100 xor.
    - 0101 srl, 1101 sra (shift amount B[4:0]).
    - 0110 or, 0111 and.
  - aluop 11: PC+gen_out (AUIPC).
- Arithmetic is 32-bit with wrap-around. slt/blt/bge are signed; the u variants are unsigned.
- Target: jalr=1 gives (A+gen_out)&~1; otherwise PC+gen_out.
- Pass-through signals are registered unchanged.

## Timing
- All outputs are registered: latency is exactly 1 cycle from the inputs, sampled at the rising clk edge.
- Forwarding muxes and the ALU are combinational within the cycle.
- rst=0 asynchronously clears every output to 0 and holds it there. This applies mid-operation too. The first capture happens at the first rising edge after rst=1.
- There is no stall or flush input. Upstream inserts bubbles by driving the control bits to 0.
- EX/MEM and MEM/WB both matching the same source: EX/MEM wins.

## Configuration
- MEM_EX_FWD_EN defined: forwarding logic is compiled in as described above.
- Not defined: operand A is readdata1 and forwarded rs2 is readdata2 everywhere. In this case ALU_result_EX_out, writingData_MEMWB, regwrite_MEMEX_out, WData_MEM_out, RS1_IDEX and RS2_IDEX are ignored.

## Test plan
- Reset: rst=0 with random inputs -> all outputs are 0 immediately and stay 0 through clock edges.
- I-add: rst=1, rs1=0xA, rs2=0xB, imm=0xF, alusrc=1, aluop=10, f3=0000, PC=0, adder1=0x10, rd=1, memtoreg=regwrite=1 -> after one edge:
  - ALU_result=0x19, readdata2=0xB, adder1_IDEX_MEM=0x10, adder2_MEM=0xF, WData=1.
- Next cycle: rs1=0xC, rs2=0x7, imm=0xC -> ALU_result=0x18, readdata2=0x7, adder2_MEM=0xC.
- Forwarding: WData_MEM_out=3, regwrite_MEMEX_out=1, writingData_MEMWB=0x100, RS1=3, readdata1=0, imm=4, alusrc=1, add -> 0x104.
  - Same case with an EX/MEM match on rd=3 and ALU_result_EX_out=0x200 -> 0x204.
  - RS1=0 -> no forwarding.
- Branch/jalr:
  - aluop=01, f3=100, rs1=0xFFFFFFFF, rs2=1 -> result 1.
  - f3=110 with the same operands -> result 0.
  - jalr, rs1=0x1001, imm=2 -> adder2_MEM=0x1002.
- Shift/sub/lui:
  - sra of 0x80000000 by 4 -> 0xF8000000.
  - f=1000 with i_type=0 -> A-B.
  - lui_flag=1 -> result equals imm.

Source files
------------

// File: rtl/mem_ex_if.sv
// ID/EX operand+control bundle into the execute stage and the EX/MEM register outputs.
// slave modport is the execute stage; master modport is the upstream/downstream environment.
interface mem_ex_if;
  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;

  // ID/EX inputs
  logic            memtoreg_IDEX_out;
  logic            regwrite_IDEX_out;
  logic            memread_IDEX_out;
  logic            memwrite_IDEX_out;
  logic            branch_IDEX_out;
  logic            alusrc_IDEX_out;
  logic            i_type_IDEX_out;
  logic            lui_flag_IDEX_out;
  logic            jalr_fla_IDEX_out;
  logic            regwrite_MEMEX_out;
  logic [1:0]      aluop_IDEX_out;
  logic [1:0]      AJ_control_IDEX_out;
  logic [XLEN-1:0] IF_IDEX_PC_ID_out;
  logic [XLEN-1:0] readdata1_IDEX_out;
  logic [XLEN-1:0] readdata2_IDEX_out;
  logic [XLEN-1:0] gen_out_IDEX_out;
  logic [XLEN-1:0] adder1_IDEX;
  logic [XLEN-1:0] writingData_MEMWB;
  logic [XLEN-1:0] ALU_result_EX_out;
  logic [3:0]      function3_out_IDEX_out;
  logic [RW-1:0]   WData_IDEX_out;
  logic [RW-1:0]   RS1_IDEX;
  logic [RW-1:0]   RS2_IDEX;
  logic [RW-1:0]   WData_MEM_out;

  // EX/MEM registered outputs
  logic            memtoreg_MEMEX_out;
  logic            memread_MEMEX_out;
  logic            memwrite_MEMEX_out;
  logic            regwrite_MEMEX_out2;
  logic [1:0]      AJ_control_MEMEX_out;
  logic [XLEN-1:0] ALU_result_MEMEX_out;
  logic [XLEN-1:0] readdata2_MEMEX_out;
  logic [XLEN-1:0] adder1_IDEX_MEM;
  logic [XLEN-1:0] adder2_MEM;
  logic [RW-1:0]   WData_MEMEX_out;
  logic [3:0]      function3_out_MEMEX_out;

  modport slave (
    input  memtoreg_IDEX_out, regwrite_IDEX_out, memread_IDEX_out, memwrite_IDEX_out,
           branch_IDEX_out, alusrc_IDEX_out, i_type_IDEX_out, lui_flag_IDEX_out,
           jalr_fla_IDEX_out, regwrite_MEMEX_out, aluop_IDEX_out, AJ_control_IDEX_out,
           IF_IDEX_PC_ID_out, readdata1_IDEX_out, readdata2_IDEX_out, gen_out_IDEX_out,
           adder1_IDEX, writingData_MEMWB, ALU_result_EX_out, function3_out_IDEX_out,
           WData_IDEX_out, RS1_IDEX, RS2_IDEX, WData_MEM_out,
    output memtoreg_MEMEX_out, memread_MEMEX_out, memwrite_MEMEX_out, regwrite_MEMEX_out2,
           AJ_control_MEMEX_out, ALU_result_MEMEX_out, readdata2_MEMEX_out, adder1_IDEX_MEM,
           adder2_MEM, WData_MEMEX_out, function3_out_MEMEX_out
  );

  modport master (
    output memtoreg_IDEX_out, regwrite_IDEX_out, memread_IDEX_out, memwrite_IDEX_out,
           branch_IDEX_out, alusrc_IDEX_out, i_type_IDEX_out, lui_flag_IDEX_out,
           jalr_fla_IDEX_out, regwrite_MEMEX_out, aluop_IDEX_out, AJ_control_IDEX_out,
           IF_IDEX_PC_ID_out, readdata1_IDEX_out, readdata2_IDEX_out, gen_out_IDEX_out,
           adder1_IDEX, writingData_MEMWB, ALU_result_EX_out, function3_out_IDEX_out,
           WData_IDEX_out, RS1_IDEX, RS2_IDEX, WData_MEM_out,
    input  memtoreg_MEMEX_out, memread_MEMEX_out, memwrite_MEMEX_out, regwrite_MEMEX_out2,
           AJ_control_MEMEX_out, ALU_result_MEMEX_out, readdata2_MEMEX_out, adder1_IDEX_MEM,
           adder2_MEM, WData_MEMEX_out, function3_out_MEMEX_out
  );
endinterface

// File: rtl/mem_ex.sv
// RV32I execute stage with EX/MEM pipeline register: forwarding, ALU, branch/jump target.
// Optional operand forwarding is compiled in when MEM_EX_FWD_EN is defined.
module mem_ex (
  input logic        clk,
  input logic        rst,
  mem_ex_if.slave    bus
);
  localparam int unsigned XLEN = 32;
  localparam int unsigned SHW  = 5;

  logic [XLEN-1:0] fwd_a_c, fwd_b_c, opb_c, alu_c, tgt_c, jalr_sum_c;
  logic [SHW-1:0]  shamt_c;
  logic            taken_c;

  // Operand forwarding: EX/MEM result has priority over MEM/WB write data
`ifdef MEM_EX_FWD_EN
  always_comb begin
    fwd_a_c = bus.readdata1_IDEX_out;
    if (bus.RS1_IDEX != '0 && bus.regwrite_MEMEX_out2 && bus.WData_MEMEX_out == bus.RS1_IDEX)
      fwd_a_c = bus.ALU_result_EX_out;
    else if (bus.RS1_IDEX != '0 && bus.regwrite_MEMEX_out && bus.WData_MEM_out == bus.RS1_IDEX)
      fwd_a_c = bus.writingData_MEMWB;

    fwd_b_c = bus.readdata2_IDEX_out;
    if (bus.RS2_IDEX != '0 && bus.regwrite_MEMEX_out2 && bus.WData_MEMEX_out == bus.RS2_IDEX)
      fwd_b_c = bus.ALU_result_EX_out;
    else if (bus.RS2_IDEX != '0 && bus.regwrite_MEMEX_out && bus.WData_MEM_out == bus.RS2_IDEX)
      fwd_b_c = bus.writingData_MEMWB;
  end
`else
  logic unused_fwd_c;
  assign unused_fwd_c = ^{bus.ALU_result_EX_out, bus.writingData_MEMWB, bus.regwrite_MEMEX_out,
                          bus.WData_MEM_out, bus.RS1_IDEX, bus.RS2_IDEX};
  always_comb begin
    fwd_a_c = bus.readdata1_IDEX_out;
    fwd_b_c = bus.readdata2_IDEX_out;
  end
`endif

  // branch_IDEX_out only qualifies the compare result downstream; not needed here
  logic unused_br_c;
  assign unused_br_c = bus.branch_IDEX_out;

  assign opb_c   = bus.alusrc_IDEX_out ? bus.gen_out_IDEX_out : fwd_b_c;
  assign shamt_c = opb_c[SHW-1:0];

  // Conditional branch comparison
  always_comb begin
    taken_c = 1'b0;
    unique case (bus.function3_out_IDEX_out[2:0])
      3'b000:  taken_c = (fwd_a_c == opb_c);
      3'b001:  taken_c = (fwd_a_c != opb_c);
      3'b100:  taken_c = ($signed(fwd_a_c) <  $signed(opb_c));
      3'b101:  taken_c = ($signed(fwd_a_c) >= $signed(opb_c));
      3'b110:  taken_c = (fwd_a_c <  opb_c);
      3'b111:  taken_c = (fwd_a_c >= opb_c);
      default: taken_c = 1'b0;
    endcase
  end

  // ALU; LUI overrides the class select
  always_comb begin
    alu_c = '0;
    if (bus.lui_flag_IDEX_out) begin
      alu_c = bus.gen_out_IDEX_out;
    end else begin
      unique case (bus.aluop_IDEX_out)
        2'b00: alu_c = fwd_a_c + opb_c;
        2'b01: alu_c = {31'b0, taken_c};
        2'b10: begin
          unique case (bus.function3_out_IDEX_out)
            4'b0000: alu_c = fwd_a_c + opb_c;
            4'b1000: alu_c = bus.i_type_IDEX_out ? fwd_a_c + opb_c : fwd_a_c - opb_c;
            4'b0001: alu_c = fwd_a_c << shamt_c;
            4'b0010: alu_c = {31'b0, $signed(fwd_a_c) < $signed(opb_c)};
            4'b0011: alu_c = {31'b0, fwd_a_c < opb_c};
            4'b0100: alu_c = fwd_a_c ^ opb_c;
            4'b0101: alu_c = fwd_a_c >> shamt_c;
            4'b1101: alu_c = XLEN'($signed(fwd_a_c) >>> shamt_c);
            4'b0110: alu_c = fwd_a_c | opb_c;
            4'b0111: alu_c = fwd_a_c & opb_c;
            default: alu_c = '0;
          endcase
        end
        default: alu_c = bus.IF_IDEX_PC_ID_out + bus.gen_out_IDEX_out;
      endcase
    end
  end

  // Branch/jump target; JALR clears bit 0
  assign jalr_sum_c = fwd_a_c + bus.gen_out_IDEX_out;
  assign tgt_c = bus.jalr_fla_IDEX_out ? {jalr_sum_c[XLEN-1:1], 1'b0}
                                       : bus.IF_IDEX_PC_ID_out + bus.gen_out_IDEX_out;

  // EX/MEM pipeline register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.memtoreg_MEMEX_out      <= 1'b0;
      bus.memread_MEMEX_out       <= 1'b0;
      bus.memwrite_MEMEX_out      <= 1'b0;
      bus.regwrite_MEMEX_out2     <= 1'b0;
      bus.AJ_control_MEMEX_out    <= '0;
      bus.ALU_result_MEMEX_out    <= '0;
      bus.readdata2_MEMEX_out     <= '0;
      bus.adder1_IDEX_MEM         <= '0;
      bus.adder2_MEM              <= '0;
      bus.WData_MEMEX_out         <= '0;
      bus.function3_out_MEMEX_out <= '0;
    end else begin
      bus.memtoreg_MEMEX_out      <= bus.memtoreg_IDEX_out;
      bus.memread_MEMEX_out       <= bus.memread_IDEX_out;
      bus.memwrite_MEMEX_out      <= bus.memwrite_IDEX_out;
      bus.regwrite_MEMEX_out2     <= bus.regwrite_IDEX_out;
      bus.AJ_control_MEMEX_out    <= bus.AJ_control_IDEX_out;
      bus.ALU_result_MEMEX_out    <= alu_c;
      bus.readdata2_MEMEX_out     <= fwd_b_c;
      bus.adder1_IDEX_MEM         <= bus.adder1_IDEX;
      bus.adder2_MEM              <= tgt_c;
      bus.WData_MEMEX_out         <= bus.WData_IDEX_out;
      bus.function3_out_MEMEX_out <= bus.function3_out_IDEX_out;
    end
  end
endmodule

// File: tb/tb_mem_ex.sv
// Scoreboard bench for mem_ex: expected EX/MEM contents queued at drive time, compared after the edge.
module tb_mem_ex;
  logic clk;
  logic rst;
  mem_ex_if bus ();

  mem_ex dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu, rd2, a1, a2;
    logic [4:0]  wd;
    logic [3:0]  f3;
    logic [1:0]  aj;
    logic        mtr, mr, mw, rw;
  } exp_t;

  exp_t sb[$];
  exp_t prev;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_outs(input string tag, input exp_t e);
    check({tag, ".alu"},  bus.ALU_result_MEMEX_out, e.alu);
    check({tag, ".rd2"},  bus.readdata2_MEMEX_out, e.rd2);
    check({tag, ".a1"},   bus.adder1_IDEX_MEM, e.a1);
    check({tag, ".a2"},   bus.adder2_MEM, e.a2);
    check({tag, ".wd"},   32'(bus.WData_MEMEX_out), 32'(e.wd));
    check({tag, ".f3"},   32'(bus.function3_out_MEMEX_out), 32'(e.f3));
    check({tag, ".aj"},   32'(bus.AJ_control_MEMEX_out), 32'(e.aj));
    check({tag, ".ctl"},  32'({bus.memtoreg_MEMEX_out, bus.memread_MEMEX_out,
                               bus.memwrite_MEMEX_out, bus.regwrite_MEMEX_out2}),
                          32'({e.mtr, e.mr, e.mw, e.rw}));
  endtask

  function automatic exp_t zero_exp();
    exp_t z;
    z.alu = '0; z.rd2 = '0; z.a1 = '0; z.a2 = '0; z.wd = '0; z.f3 = '0; z.aj = '0;
    z.mtr = 1'b0; z.mr = 1'b0; z.mw = 1'b0; z.rw = 1'b0;
    return z;
  endfunction

  // Reference model of one EX cycle; EX/MEM state for forwarding comes from prev
  function automatic exp_t model();
    exp_t e;
    logic [31:0] a, r2, b, pc, imm, s;
    logic signed [31:0] sa, sb_;
    logic [3:0] f;
    a = bus.readdata1_IDEX_out;
    r2 = bus.readdata2_IDEX_out;
`ifdef MEM_EX_FWD_EN
    if (bus.RS1_IDEX != 0 && prev.rw && prev.wd == bus.RS1_IDEX) a = bus.ALU_result_EX_out;
    else if (bus.RS1_IDEX != 0 && bus.regwrite_MEMEX_out && bus.WData_MEM_out == bus.RS1_IDEX)
      a = bus.writingData_MEMWB;
    if (bus.RS2_IDEX != 0 && prev.rw && prev.wd == bus.RS2_IDEX) r2 = bus.ALU_result_EX_out;
    else if (bus.RS2_IDEX != 0 && bus.regwrite_MEMEX_out && bus.WData_MEM_out == bus.RS2_IDEX)
      r2 = bus.writingData_MEMWB;
`endif
    imm = bus.gen_out_IDEX_out;
    pc  = bus.IF_IDEX_PC_ID_out;
    b   = bus.alusrc_IDEX_out ? imm : r2;
    sa  = a; sb_ = b;
    f   = bus.function3_out_IDEX_out;
    s   = 32'h0;
    if (bus.lui_flag_IDEX_out) s = imm;
    else if (bus.aluop_IDEX_out == 2'd0) s = a + b;
    else if (bus.aluop_IDEX_out == 2'd3) s = pc + imm;
    else if (bus.aluop_IDEX_out == 2'd1) begin
      case (f[2:0])
        3'd0: s = (a == b) ? 1 : 0;
        3'd1: s = (a != b) ? 1 : 0;
        3'd4: s = (sa < sb_) ? 1 : 0;
        3'd5: s = (sa >= sb_) ? 1 : 0;
        3'd6: s = (a < b) ? 1 : 0;
        3'd7: s = (a >= b) ? 1 : 0;
        default: s = 0;
      endcase
    end else begin
      case (f)
        4'h0: s = a + b;
        4'h8: s = bus.i_type_IDEX_out ? a + b : a - b;
        4'h1: s = a << b[4:0];
        4'h2: s = (sa < sb_) ? 1 : 0;
        4'h3: s = (a < b) ? 1 : 0;
        4'h4: s = a ^ b;
        4'h5: s = a >> b[4:0];
        4'hD: s = 32'(sa >>> b[4:0]);
        4'h6: s = a | b;
        4'h7: s = a & b;
        default: s = 0;
      endcase
    end
    e.alu = s;
    e.rd2 = r2;
    e.a1  = bus.adder1_IDEX;
    e.a2  = bus.jalr_fla_IDEX_out ? ((a + imm) & 32'hFFFF_FFFE) : pc + imm;
    e.wd  = bus.WData_IDEX_out;
    e.f3  = f;
    e.aj  = bus.AJ_control_IDEX_out;
    e.mtr = bus.memtoreg_IDEX_out;
    e.mr  = bus.memread_IDEX_out;
    e.mw  = bus.memwrite_IDEX_out;
    e.rw  = bus.regwrite_IDEX_out;
    return e;
  endfunction

  task automatic clear_in();
    {bus.memtoreg_IDEX_out, bus.regwrite_IDEX_out, bus.memread_IDEX_out, bus.memwrite_IDEX_out,
     bus.branch_IDEX_out, bus.alusrc_IDEX_out, bus.i_type_IDEX_out, bus.lui_flag_IDEX_out,
     bus.jalr_fla_IDEX_out, bus.regwrite_MEMEX_out} = '0;
    bus.aluop_IDEX_out = '0; bus.AJ_control_IDEX_out = '0;
    bus.IF_IDEX_PC_ID_out = '0; bus.readdata1_IDEX_out = '0; bus.readdata2_IDEX_out = '0;
    bus.gen_out_IDEX_out = '0; bus.adder1_IDEX = '0; bus.writingData_MEMWB = '0;
    bus.ALU_result_EX_out = '0; bus.function3_out_IDEX_out = '0;
    bus.WData_IDEX_out = '0; bus.RS1_IDEX = '0; bus.RS2_IDEX = '0; bus.WData_MEM_out = '0;
  endtask

  task automatic rand_in();
    {bus.memtoreg_IDEX_out, bus.regwrite_IDEX_out, bus.memread_IDEX_out, bus.memwrite_IDEX_out,
     bus.branch_IDEX_out, bus.alusrc_IDEX_out, bus.i_type_IDEX_out, bus.regwrite_MEMEX_out} =
      8'($urandom);
    bus.lui_flag_IDEX_out = ($urandom_range(0, 7) == 0);
    bus.jalr_fla_IDEX_out = ($urandom_range(0, 3) == 0);
    bus.aluop_IDEX_out = 2'($urandom); bus.AJ_control_IDEX_out = 2'($urandom);
    bus.IF_IDEX_PC_ID_out = $urandom; bus.readdata1_IDEX_out = $urandom;
    bus.readdata2_IDEX_out = $urandom; bus.gen_out_IDEX_out = $urandom;
    bus.adder1_IDEX = $urandom; bus.writingData_MEMWB = $urandom;
    bus.ALU_result_EX_out = $urandom; bus.function3_out_IDEX_out = 4'($urandom);
    bus.WData_IDEX_out = 5'($urandom_range(0, 3)); bus.RS1_IDEX = 5'($urandom_range(0, 3));
    bus.RS2_IDEX = 5'($urandom_range(0, 3)); bus.WData_MEM_out = 5'($urandom_range(0, 3));
  endtask

  // Push expectation, clock once, pop and compare
  task automatic step(input string tag);
    exp_t e;
    sb.push_back(model());
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, ".sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      compare_outs(tag, e);
      prev = e;
    end
  endtask

  initial begin
    prev = zero_exp();
    rst = 1'b0;
    rand_in();
    #1;
    compare_outs("rst_now", zero_exp());
    repeat (2) @(posedge clk);
    #1;
    compare_outs("rst_hold", zero_exp());
    rst = 1'b1;

    // I-type add
    clear_in();
    bus.readdata1_IDEX_out = 32'hA; bus.readdata2_IDEX_out = 32'hB; bus.gen_out_IDEX_out = 32'hF;
    bus.alusrc_IDEX_out = 1'b1; bus.aluop_IDEX_out = 2'b10; bus.adder1_IDEX = 32'h10;
    bus.WData_IDEX_out = 5'd1; bus.memtoreg_IDEX_out = 1'b1; bus.regwrite_IDEX_out = 1'b1;
    step("iadd");
    check("iadd_const", bus.ALU_result_MEMEX_out, 32'h19);
    check("iadd_tgt", bus.adder2_MEM, 32'hF);

    bus.readdata1_IDEX_out = 32'hC; bus.readdata2_IDEX_out = 32'h7; bus.gen_out_IDEX_out = 32'hC;
    step("iadd2");
    check("iadd2_const", bus.ALU_result_MEMEX_out, 32'h18);

    // Forwarding from MEM/WB, then EX/MEM priority, then x0
    clear_in();
    bus.WData_MEM_out = 5'd3; bus.regwrite_MEMEX_out = 1'b1; bus.writingData_MEMWB = 32'h100;
    bus.RS1_IDEX = 5'd3; bus.gen_out_IDEX_out = 32'h4; bus.alusrc_IDEX_out = 1'b1;
    bus.WData_IDEX_out = 5'd3; bus.regwrite_IDEX_out = 1'b1;
    step("fwd_wb");
`ifdef MEM_EX_FWD_EN
    check("fwd_wb_const", bus.ALU_result_MEMEX_out, 32'h104);
`else
    check("fwd_wb_const", bus.ALU_result_MEMEX_out, 32'h4);
`endif
    bus.ALU_result_EX_out = 32'h200;
    step("fwd_ex");
`ifdef MEM_EX_FWD_EN
    check("fwd_ex_const", bus.ALU_result_MEMEX_out, 32'h204);
`else
    check("fwd_ex_const", bus.ALU_result_MEMEX_out, 32'h4);
`endif
    bus.RS1_IDEX = 5'd0;
    step("fwd_x0");
    check("fwd_x0_const", bus.ALU_result_MEMEX_out, 32'h4);

    // Branch compares and JALR target
    clear_in();
    bus.aluop_IDEX_out = 2'b01; bus.function3_out_IDEX_out = 4'b0100;
    bus.readdata1_IDEX_out = 32'hFFFF_FFFF; bus.readdata2_IDEX_out = 32'h1;
    step("blt");
    check("blt_const", bus.ALU_result_MEMEX_out, 32'h1);
    bus.function3_out_IDEX_out = 4'b0110;
    step("bltu");
    check("bltu_const", bus.ALU_result_MEMEX_out, 32'h0);
    clear_in();
    bus.jalr_fla_IDEX_out = 1'b1; bus.readdata1_IDEX_out = 32'h1001; bus.gen_out_IDEX_out = 32'h2;
    step("jalr");
    check("jalr_const", bus.adder2_MEM, 32'h1002);

    // sra, sub, lui
    clear_in();
    bus.aluop_IDEX_out = 2'b10; bus.function3_out_IDEX_out = 4'b1101; bus.alusrc_IDEX_out = 1'b1;
    bus.readdata1_IDEX_out = 32'h8000_0000; bus.gen_out_IDEX_out = 32'h4;
    step("sra");
    check("sra_const", bus.ALU_result_MEMEX_out, 32'hF800_0000);
    bus.function3_out_IDEX_out = 4'b1000; bus.alusrc_IDEX_out = 1'b0;
    bus.readdata1_IDEX_out = 32'h3; bus.readdata2_IDEX_out = 32'h5;
    step("sub");
    check("sub_const", bus.ALU_result_MEMEX_out, 32'hFFFF_FFFE);
    bus.lui_flag_IDEX_out = 1'b1; bus.gen_out_IDEX_out = 32'hABCD_E000;
    step("lui");
    check("lui_const", bus.ALU_result_MEMEX_out, 32'hABCD_E000);

    // Random traffic exercising forwarding chains
    for (int i = 0; i < 60; i++) begin
      rand_in();
      step("rand");
    end

    // Mid-operation asynchronous reset
    rand_in();
    @(negedge clk);
    rst = 1'b0;
    #1;
    compare_outs("rst_mid", zero_exp());
    @(posedge clk);
    #1;
    compare_outs("rst_mid_hold", zero_exp());
    prev = zero_exp();
    rst = 1'b1;
    rand_in();
    step("post_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
